// File: rtl/run_state_ctrl.sv
// run_state_ctrl: per-channel start/stop run latch with edge detect, transition pulses
// and saturating run-time counters. Define STATE_HOLDOFF_EN for a post-transition lockout.
module run_state_ctrl #(
    parameter int CH            = 4,
    parameter int CNT_W         = 16,
    parameter int STOP_PRIORITY = 1,
    parameter int CLR_ON_START  = 0,
    parameter int HOLDOFF_CYC   = 1000
) (
    input  logic                clk_50MHz,
    input  logic                rst_n,
    input  logic [CH-1:0]       start,
    input  logic [CH-1:0]       stop,
    input  logic [CH-1:0]       toggle_mode,
    input  logic                tick,
    input  logic [CH-1:0]       cnt_clr,
    output logic [CH-1:0]       run,
    output logic [CH-1:0]       run_rise,
    output logic [CH-1:0]       run_fall,
    output logic [CH*CNT_W-1:0] run_cnt,
    output logic [CH-1:0]       cnt_sat
);

    if (CH < 1 || CH > 16 || CNT_W < 1 || HOLDOFF_CYC < 1) begin : g_bad_cfg
        $error("run_state_ctrl: parameter out of range");
    end

    logic [CH-1:0] r_start_d;
    logic [CH-1:0] r_stop_d;
    logic [CH-1:0] r_run;
    logic [CH-1:0] r_rise;
    logic [CH-1:0] r_fall;
    logic [CH-1:0] w_block;
    logic [CH-1:0] w_ev_start;
    logic [CH-1:0] w_ev_stop;
    logic [CH-1:0] w_run_nxt;

    assign w_ev_start = start & ~r_start_d & ~w_block;
    assign w_ev_stop  = stop & ~r_stop_d & ~w_block;

    always_comb begin
        w_run_nxt = r_run;
        for (int i = 0; i < CH; i++) begin
            case ({w_ev_start[i], w_ev_stop[i]})
                2'b10: w_run_nxt[i] = toggle_mode[i] ? ~r_run[i] : 1'b1;
                2'b01: w_run_nxt[i] = 1'b0;
                2'b11: begin
                    if (STOP_PRIORITY != 0)
                        w_run_nxt[i] = 1'b0;
                    else
                        w_run_nxt[i] = toggle_mode[i] ? ~r_run[i] : 1'b1;
                end
                default: w_run_nxt[i] = r_run[i];
            endcase
        end
    end

    // History resets high so a button held through reset release is not an edge.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d <= '1;
            r_stop_d  <= '1;
            r_run     <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
        end else begin
            r_start_d <= start;
            r_stop_d  <= stop;
            r_run     <= w_run_nxt;
            r_rise    <= w_run_nxt & ~r_run;
            r_fall    <= ~w_run_nxt & r_run;
        end
    end

    assign run      = r_run;
    assign run_rise = r_rise;
    assign run_fall = r_fall;

`ifdef STATE_HOLDOFF_EN
    localparam int HO_W = $clog2(HOLDOFF_CYC + 1);

    for (genvar i = 0; i < CH; i++) begin : g_ho
        logic [HO_W-1:0] r_ho;

        always_ff @(posedge clk_50MHz or negedge rst_n) begin
            if (!rst_n)
                r_ho <= '0;
            else if (w_run_nxt[i] != r_run[i])
                r_ho <= HO_W'(HOLDOFF_CYC);
            else if (r_ho != '0)
                r_ho <= r_ho - HO_W'(1);
        end

        assign w_block[i] = (r_ho != '0);
    end
`else
    assign w_block = '0;
`endif

    for (genvar i = 0; i < CH; i++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        logic             r_sat;
        logic [CNT_W-1:0] w_inc;
        logic             w_all1;
        logic             w_clr_start;

        assign w_inc       = r_cnt + CNT_W'(1);
        assign w_all1      = &r_cnt;
        assign w_clr_start = (CLR_ON_START != 0) && !r_run[i] && w_run_nxt[i];

        // Counting uses the pre-update run value; saturation holds at all-ones.
        always_ff @(posedge clk_50MHz or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (cnt_clr[i] || w_clr_start) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (r_run[i] && tick && !w_all1) begin
                r_cnt <= w_inc;
                r_sat <= &w_inc;
            end
        end

        assign run_cnt[i*CNT_W +: CNT_W] = r_cnt;
        assign cnt_sat[i]                = r_sat;
    end

endmodule

// File: tb/tb_run_state_ctrl.sv
// Directed bench for run_state_ctrl: two instances differing in priority and
// clear-on-start, driven by shared stimulus with hand-computed expectations.
module tb_run_state_ctrl;

    localparam int CH = 4;
    localparam int CW = 4;
    localparam int HO = 8;
`ifdef STATE_HOLDOFF_EN
    localparam bit HO_ON = 1'b1;
`else
    localparam bit HO_ON = 1'b0;
`endif
    localparam int GAP = HO_ON ? 10 : 5;

    logic clk = 1'b0;
    logic rst_n;
    logic [CH-1:0] start, stop, toggle_mode, cnt_clr;
    logic tick;

    logic [CH-1:0]    run_a, rise_a, fall_a, sat_a;
    logic [CH*CW-1:0] cnt_a;
    logic [CH-1:0]    run_b, rise_b, fall_b, sat_b;
    logic [CH*CW-1:0] cnt_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    run_state_ctrl #(
        .CH(CH), .CNT_W(CW), .STOP_PRIORITY(1),
        .CLR_ON_START(0), .HOLDOFF_CYC(HO)
    ) dut_a (
        .clk_50MHz(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .toggle_mode(toggle_mode), .tick(tick), .cnt_clr(cnt_clr),
        .run(run_a), .run_rise(rise_a), .run_fall(fall_a),
        .run_cnt(cnt_a), .cnt_sat(sat_a)
    );

    run_state_ctrl #(
        .CH(CH), .CNT_W(CW), .STOP_PRIORITY(0),
        .CLR_ON_START(1), .HOLDOFF_CYC(HO)
    ) dut_b (
        .clk_50MHz(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .toggle_mode(toggle_mode), .tick(tick), .cnt_clr(cnt_clr),
        .run(run_b), .run_rise(rise_b), .run_fall(fall_b),
        .run_cnt(cnt_b), .cnt_sat(sat_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        logic any_pulse;
        rst_n = 1'b1;
        start = '0; stop = '0; toggle_mode = '0; cnt_clr = '0; tick = 1'b0;
        #2;
        rst_n = 1'b0;
        start = 4'b0001;
        idle(3);
        chk("rst_run", 32'(run_a), 0);
        chk("rst_pulse", 32'(rise_a | fall_a), 0);
        chk("rst_cnt", 32'(cnt_a), 0);
        chk("rst_sat", 32'(sat_a | sat_b), 0);

        // start held through release must not act
        rst_n = 1'b1;
        any_pulse = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            any_pulse |= rise_a[0] | rise_b[0];
        end
        chk("held_run", 32'(run_a[0] | run_b[0]), 0);
        chk("held_pulse", 32'(any_pulse), 0);

        start = '0;
        step();
        start = 4'b0001;
        step();
        chk("fresh_run_a", 32'(run_a[0]), 1);
        chk("fresh_rise_a", 32'(rise_a[0]), 1);
        chk("fresh_run_b", 32'(run_b[0]), 1);
        step();
        chk("rise_one_cyc", 32'(rise_a[0]), 0);
        start = '0;
        idle(GAP);
        start = 4'b0001;
        step();
        chk("start_while_run", 32'(rise_a[0]), 0);
        chk("still_run", 32'(run_a[0]), 1);
        start = '0;
        idle(GAP);
        stop = 4'b0001;
        step();
        chk("stop_run", 32'(run_a[0]), 0);
        chk("stop_fall", 32'(fall_a[0]), 1);
        stop = '0;
        idle(GAP);

        // simultaneous start+stop, normal mode
        start = 4'b0010;
        stop  = 4'b0010;
        step();
        chk("both_sp1_run", 32'(run_a[1]), 0);
        chk("both_sp1_pulse", 32'(rise_a[1] | fall_a[1]), 0);
        chk("both_sp0_run", 32'(run_b[1]), 1);
        chk("both_sp0_rise", 32'(rise_b[1]), 1);
        start = '0;
        stop  = '0;
        idle(GAP);
        stop = 4'b0010;
        step();
        chk("b_ch1_stop", 32'(run_b[1]), 0);
        stop = '0;
        idle(GAP);

        // toggle mode on ch2
        toggle_mode = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            logic e;
            e = (k % 2 == 0);
            start = 4'b0100;
            step();
            chk("tog_run", 32'(run_a[2]), 32'(e));
            chk("tog_rise", 32'(rise_a[2]), 32'(e));
            chk("tog_fall", 32'(fall_a[2]), 32'(!e));
            chk("tog_run_b", 32'(run_b[2]), 32'(e));
            start = '0;
            idle(GAP - 1);
        end
        stop = 4'b0100;
        step();
        chk("tog_stop_run", 32'(run_a[2] | run_b[2]), 0);
        chk("tog_stop_fall", 32'(fall_a[2]), 1);
        stop = '0;
        idle(GAP);
        start = 4'b0100;
        stop  = 4'b0100;
        step();
        chk("tog_both_sp1", 32'(run_a[2]), 0);
        chk("tog_both_sp0", 32'(run_b[2]), 1);
        start = '0;
        stop  = '0;
        idle(GAP);
        stop = 4'b0100;
        step();
        chk("tog_b_stop", 32'(run_b[2]), 0);
        stop = '0;
        toggle_mode = '0;
        idle(GAP);

        // counter saturation on ch3
        start = 4'b1000;
        step();
        chk("ch3_run", 32'(run_a[3]), 1);
        start = '0;
        tick = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 14) begin
                chk("cnt14", 32'(cnt_a[15:12]), 14);
                chk("sat14", 32'(sat_a[3]), 0);
            end
            if (k == 15) begin
                chk("cnt15", 32'(cnt_a[15:12]), 15);
                chk("sat15", 32'(sat_a[3]), 1);
            end
        end
        chk("cnt_nowrap", 32'(cnt_a[15:12]), 15);
        chk("sat_sticky", 32'(sat_a[3]), 1);
        chk("cnt_b_sat", 32'(cnt_b[15:12]), 15);
        chk("other_cnt", 32'(cnt_a[11:0]), 0);
        cnt_clr = 4'b1000;
        step();
        chk("clr_cnt", 32'(cnt_a[15:12]), 0);
        chk("clr_sat", 32'(sat_a[3]), 0);
        cnt_clr = '0;
        step();
        chk("cnt_after_clr", 32'(cnt_a[15:12]), 1);

        // clear-on-start
        idle(6);
        tick = 1'b0;
        chk("cnt7_a", 32'(cnt_a[15:12]), 7);
        chk("cnt7_b", 32'(cnt_b[15:12]), 7);
        stop = 4'b1000;
        step();
        chk("ch3_stopped", 32'(run_a[3] | run_b[3]), 0);
        stop = '0;
        idle(GAP);
        tick  = 1'b1;
        start = 4'b1000;
        step();
        chk("cos_off_keep", 32'(cnt_a[15:12]), 7);
        chk("cos_clear", 32'(cnt_b[15:12]), 0);
        chk("cos_run", 32'(run_b[3]), 1);
        step();
        chk("cos_tick_b", 32'(cnt_b[15:12]), 1);
        chk("cos_tick_a", 32'(cnt_a[15:12]), 8);
        tick  = 1'b0;
        start = '0;

        // holdoff: stop 3 cycles after start
        idle(GAP);
        start = 4'b0001;
        step();
        chk("ho_start", 32'(run_a[0]), 1);
        start = '0;
        idle(2);
        stop = 4'b0001;
        step();
        chk("ho_early_stop", 32'(run_a[0]), HO_ON ? 32'd1 : 32'd0);
        stop = '0;
        idle(6);
        stop = 4'b0001;
        step();
        chk("ho_late_stop", 32'(run_a[0] | run_b[0]), 0);
        stop = '0;

        // reset while ch3 runs
        tick = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_run", 32'(run_a | run_b), 0);
        chk("async_rst_cnt", 32'(cnt_a | cnt_b), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_run", 32'(run_a), 0);
        start = 4'b1000;
        step();
        chk("post_rst_start", 32'(run_a[3]), 1);
        tick  = 1'b0;
        start = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
